// File: rtl/washer_seq_ctrl.sv
// Washer sequencer: fill/wash/drain/N x rinse/spin with load-scaled wash, door pause/resume.
// Outputs registered from next state; optional prewash phases under WASHER_PREWASH_EN.
module washer_seq_ctrl #(
    parameter int LOAD_W    = 2,
    parameter int CNT_W     = 8,
    parameter int FILL_T    = 4,
    parameter int WASH_BASE = 8,
    parameter int WASH_STEP = 4,
    parameter int DRAIN_T   = 4,
    parameter int RINSE_T   = 6,
    parameter int RINSE_N   = 1,
    parameter int SPIN_T    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic              Door,
    input  logic [LOAD_W-1:0] load,
    output logic              Agitator,
    output logic              Motor,
    output logic              Pump,
    output logic              Speed,
    output logic              Water,
    output logic              Done,
    output logic [3:0]        phase
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FILL   = 4'd1,
        S_WASH   = 4'd2,
        S_DRAIN  = 4'd3,
        S_RFILL  = 4'd4,
        S_RINSE  = 4'd5,
        S_RDRAIN = 4'd6,
        S_SPIN   = 4'd7,
        S_DONE   = 4'd8,
        S_PAUSE  = 4'd9
`ifdef WASHER_PREWASH_EN
        ,
        S_PFILL  = 4'd10,
        S_PWASH  = 4'd11,
        S_PDRAIN = 4'd12
`endif
    } state_t;

`ifdef WASHER_PREWASH_EN
    localparam state_t FIRST_S = S_PFILL;
`else
    localparam state_t FIRST_S = S_FILL;
`endif

    localparam int RC_W     = (RINSE_N > 1) ? $clog2(RINSE_N + 1) : 1;
    localparam int WASH_MAX = WASH_BASE + ((1 << LOAD_W) - 1) * WASH_STEP;

    generate
        if (WASH_MAX >= (1 << CNT_W)) begin : g_wash_range
            $error("washer_seq_ctrl: maximum wash time does not fit in CNT_W bits");
        end
        if (FILL_T < 1 || WASH_BASE < 1 || DRAIN_T < 1 || RINSE_T < 1 || SPIN_T < 1) begin : g_dur_range
            $error("washer_seq_ctrl: every phase duration must be at least one cycle");
        end
    endgenerate

    state_t            state_q, state_d, saved_q, saved_d, adv;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [RC_W-1:0]   rinse_q, rinse_d, rinse_inc;
    logic [LOAD_W-1:0] load_q, load_d;
    logic [5:0]        outs_q, outs_d;

    // Timer reload value (duration - 1) for the state being entered.
    function automatic logic [CNT_W-1:0] dur_m1(input state_t s, input logic [LOAD_W-1:0] ld);
        logic [CNT_W-1:0] d;
        d = '0;
        case (s)
            S_FILL, S_RFILL:  d = CNT_W'(FILL_T - 1);
            S_WASH:           d = CNT_W'(WASH_BASE) + CNT_W'(WASH_STEP) * CNT_W'(ld) - CNT_W'(1);
            S_DRAIN, S_RDRAIN: d = CNT_W'(DRAIN_T - 1);
            S_RINSE:          d = CNT_W'(RINSE_T - 1);
            S_SPIN:           d = CNT_W'(SPIN_T - 1);
`ifdef WASHER_PREWASH_EN
            S_PFILL:          d = CNT_W'(FILL_T - 1);
            S_PWASH:          d = CNT_W'(WASH_BASE - 1);
            S_PDRAIN:         d = CNT_W'(DRAIN_T - 1);
`endif
            default:          d = '0;
        endcase
        return d;
    endfunction

    // {Agitator, Motor, Pump, Speed, Water, Done}
    function automatic logic [5:0] decode(input state_t s);
        logic [5:0] o;
        o = 6'b000000;
        case (s)
            S_FILL, S_RFILL:   o = 6'b000010;
            S_WASH, S_RINSE:   o = 6'b110000;
            S_DRAIN, S_RDRAIN: o = 6'b001000;
            S_SPIN:            o = 6'b011100;
            S_DONE:            o = 6'b000001;
`ifdef WASHER_PREWASH_EN
            S_PFILL:           o = 6'b000010;
            S_PWASH:           o = 6'b110000;
            S_PDRAIN:          o = 6'b001000;
`endif
            default:           o = 6'b000000;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        saved_d   = saved_q;
        rinse_d   = rinse_q;
        load_d    = load_q;
        adv       = S_IDLE;
        rinse_inc = rinse_q + RC_W'(1);

        case (state_q)
            S_FILL:   adv = S_WASH;
            S_WASH:   adv = S_DRAIN;
            S_DRAIN:  adv = (RINSE_N == 0) ? S_SPIN : S_RFILL;
            S_RFILL:  adv = S_RINSE;
            S_RINSE:  adv = S_RDRAIN;
            S_RDRAIN: adv = (rinse_inc == RC_W'(RINSE_N)) ? S_SPIN : S_RFILL;
            S_SPIN:   adv = S_DONE;
`ifdef WASHER_PREWASH_EN
            S_PFILL:  adv = S_PWASH;
            S_PWASH:  adv = S_PDRAIN;
            S_PDRAIN: adv = S_FILL;
`endif
            default:  adv = S_IDLE;
        endcase

        case (state_q)
            S_IDLE: begin
                if (Start && !Door) begin
                    load_d  = load;
                    rinse_d = '0;
                    state_d = FIRST_S;
                    timer_d = dur_m1(FIRST_S, load);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_PAUSE: begin
                if (!Door) begin
                    state_d = saved_q;
                end
            end
            default: begin
                // Door beats expiry: the timer stays frozen, so a pause on the
                // last cycle still leaves that cycle to run after resume.
                if (Door) begin
                    saved_d = state_q;
                    state_d = S_PAUSE;
                end else if (timer_q == '0) begin
                    state_d = adv;
                    timer_d = dur_m1(adv, load_q);
                    if (state_q == S_RDRAIN) begin
                        rinse_d = rinse_inc;
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
        endcase

        outs_d = decode(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            saved_q <= S_IDLE;
            timer_q <= '0;
            rinse_q <= '0;
            load_q  <= '0;
            outs_q  <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            timer_q <= timer_d;
            rinse_q <= rinse_d;
            load_q  <= load_d;
            outs_q  <= outs_d;
        end
    end

    assign {Agitator, Motor, Pump, Speed, Water, Done} = outs_q;
    assign phase = state_q;

endmodule

// File: tb/tb_washer_seq_ctrl.sv
// Directed bench for washer_seq_ctrl: table-driven program runs plus door/reset corner sequences.
module tb_washer_seq_ctrl;

`ifdef WASHER_PREWASH_EN
    localparam int         PRE       = 16;
    localparam logic [3:0] FIRST_PH  = 4'd10;
    localparam logic [3:0] SECOND_PH = 4'd11;
`else
    localparam int         PRE       = 0;
    localparam logic [3:0] FIRST_PH  = 4'd1;
    localparam logic [3:0] SECOND_PH = 4'd2;
`endif

    logic       clk, reset, Start, Door;
    logic [1:0] load;
    logic       Agitator, Motor, Pump, Speed, Water, Done;
    logic [3:0] phase;
    logic       d0_Agitator, d0_Motor, d0_Pump, d0_Speed, d0_Water, d0_Done;
    logic [3:0] d0_phase;
    logic [5:0] outs;

    assign outs = {Agitator, Motor, Pump, Speed, Water, Done};

    washer_seq_ctrl u_dut (
        .clk(clk), .reset(reset), .Start(Start), .Door(Door), .load(load),
        .Agitator(Agitator), .Motor(Motor), .Pump(Pump), .Speed(Speed),
        .Water(Water), .Done(Done), .phase(phase)
    );

    washer_seq_ctrl #(.RINSE_N(0)) u_dut_norinse (
        .clk(clk), .reset(reset), .Start(Start), .Door(Door), .load(load),
        .Agitator(d0_Agitator), .Motor(d0_Motor), .Pump(d0_Pump), .Speed(d0_Speed),
        .Water(d0_Water), .Done(d0_Done), .phase(d0_phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] ph;
        int         dur;
        logic [5:0] o;
    } seg_t;

    typedef struct {
        logic [1:0] ld;
        int         wash_len;
        int         exp_done;
        bit         hold;
    } run_t;

    seg_t segs[$];
    run_t runs[3];
    int   vecs;
    int   errs;

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input string name, input logic [3:0] ph, input logic [5:0] o);
        @(negedge clk);
        chk({name, " phase"}, int'(phase), int'(ph));
        chk({name, " outs"}, int'(outs), int'(o));
    endtask

    task automatic run_prog(input run_t r);
        int cyc, d, done_at, done_cnt, d0_at;
        cyc = 0; done_at = -1; done_cnt = 0; d0_at = -1;
        @(negedge clk);
        Start = 1'b1;
        load  = r.ld;
        foreach (segs[i]) begin
            d = (segs[i].ph == 4'd2) ? r.wash_len : segs[i].dur;
            for (int c = 0; c < d; c++) begin
                @(negedge clk);
                cyc++;
                if (!r.hold) Start = 1'b0;
                chk($sformatf("run%0d c%0d phase", r.ld, cyc), int'(phase), int'(segs[i].ph));
                chk($sformatf("run%0d c%0d outs", r.ld, cyc), int'(outs), int'(segs[i].o));
                if (Done) begin
                    done_at = cyc;
                    done_cnt++;
                end
                if (d0_Done) d0_at = cyc;
            end
        end
        Start = 1'b0;
        step($sformatf("run%0d idle", r.ld), 4'd0, 6'b000000);
        chk($sformatf("run%0d done cycle", r.ld), done_at, r.exp_done);
        chk($sformatf("run%0d done count", r.ld), done_cnt, 1);
        // No-rinse build: fill + wash + drain + spin, Done on the following cycle.
        chk($sformatf("run%0d norinse done cycle", r.ld), d0_at, PRE + 4 + r.wash_len + 4 + 6 + 1);
    endtask

    initial begin
        vecs = 0; errs = 0;
        reset = 1'b0; Start = 1'b0; Door = 1'b0; load = 2'd0;

`ifdef WASHER_PREWASH_EN
        segs.push_back('{4'd10, 4, 6'b000010});
        segs.push_back('{4'd11, 8, 6'b110000});
        segs.push_back('{4'd12, 4, 6'b001000});
`endif
        segs.push_back('{4'd1, 4, 6'b000010});
        segs.push_back('{4'd2, 8, 6'b110000});
        segs.push_back('{4'd3, 4, 6'b001000});
        segs.push_back('{4'd4, 4, 6'b000010});
        segs.push_back('{4'd5, 6, 6'b110000});
        segs.push_back('{4'd6, 4, 6'b001000});
        segs.push_back('{4'd7, 6, 6'b011100});
        segs.push_back('{4'd8, 1, 6'b000001});

        runs[0] = '{2'd0,  8, 37 + PRE, 1'b0};
        runs[1] = '{2'd2, 16, 45 + PRE, 1'b0};
        runs[2] = '{2'd3, 20, 49 + PRE, 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset phase", int'(phase), 0);
        chk("reset outs", int'(outs), 0);
        reset = 1'b1;
        step("post-reset idle", 4'd0, 6'b000000);

        foreach (runs[i]) run_prog(runs[i]);

        // Door open in IDLE blocks Start; closing it with Start high starts next edge.
        @(negedge clk);
        Start = 1'b1; Door = 1'b1;
        for (int i = 0; i < 3; i++) step("idle door blocks", 4'd0, 6'b000000);
        Door = 1'b0;
        step("idle door released", FIRST_PH, 6'b000010);
        Start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Five-cycle pause mid-SPIN: six extra cycles, SPIN resumes its count.
        @(negedge clk);
        Start = 1'b1; load = 2'd0;
        for (int c = 1; c <= 32 + PRE; c++) begin
            @(negedge clk);
            Start = 1'b0;
        end
        chk("spin before pause", int'(phase), 7);
        Door = 1'b1;
        for (int i = 0; i < 5; i++) step("spin pause", 4'd9, 6'b000000);
        Door = 1'b0;
        for (int i = 0; i < 5; i++) step("spin resumed", 4'd7, 6'b011100);
        step("spin pause done", 4'd8, 6'b000001);
        step("spin pause idle", 4'd0, 6'b000000);

        // Door on the final cycle of the first phase: one more cycle after resume.
        @(negedge clk);
        Start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            Start = 1'b0;
        end
        chk("last-cycle before pause", int'(phase), int'(FIRST_PH));
        Door = 1'b1;
        step("last-cycle pause", 4'd9, 6'b000000);
        Door = 1'b0;
        step("last-cycle resumed", FIRST_PH, 6'b000010);
        step("last-cycle advance", SECOND_PH, 6'b110000);

        // Asynchronous reset in the middle of the agitate phase.
        #2;
        reset = 1'b0;
        #1;
        chk("async reset phase", int'(phase), 0);
        chk("async reset outs", int'(outs), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step("after reset no start", 4'd0, 6'b000000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
